wash_ctrl: RTL and testbench

WASH_CTRL -- requirements
Module: wash_ctrl

---
 rtl/wash_ctrl.sv | 120 ++++++++++++
 tb/tb_wash_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/wash_ctrl.sv
// Washing-machine program sequencer: supply -> wash -> drain -> dewater rounds, then alarm.
// Gray-coded state drives the external timer block; actuator outputs are registered from next state.
module wash_ctrl #(
  parameter int          ROUNDS     = 3,
  parameter logic [15:0] SUPPLY_TMO = 16'd60000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       water_full,
  input  logic       wash,
  input  logic       water,
  input  logic       dewater,
  input  logic       alarm,
  output logic [2:0] state_out,
  output logic       valve_in,
  output logic       motor,
  output logic       valve_out,
  output logic       buzzer,
  output logic [1:0] round_cnt,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_SUPPLY  = 3'b001,
    S_WASH    = 3'b011,
    S_DRAIN   = 3'b010,
    S_DEWATER = 3'b110,
    S_ALARM   = 3'b100
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [15:0] supply_cnt;
  logic [15:0] cnt_nxt;
  logic [1:0]  rc_nxt;
  logic [1:0]  rc_inc;
  logic        flt_nxt;

  assign rc_inc = (round_cnt == 2'd3) ? 2'd3 : round_cnt + 2'd1;

  always_comb begin
    nxt     = state;
    cnt_nxt = supply_cnt;
    rc_nxt  = round_cnt;
    flt_nxt = fault;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          nxt     = S_SUPPLY;
          rc_nxt  = 2'd0;
          flt_nxt = 1'b0;
          cnt_nxt = 16'd0;
        end
      end
      S_SUPPLY: begin
        if (abort) begin
          nxt = S_IDLE;
        end else if (water_full) begin
          nxt     = S_WASH;
          cnt_nxt = 16'd0;
        end else if (supply_cnt == SUPPLY_TMO - 16'd1) begin
          nxt     = S_ALARM;
          flt_nxt = 1'b1;
        end else if (supply_cnt != 16'hFFFF) begin
          cnt_nxt = supply_cnt + 16'd1;
        end
      end
      S_WASH: begin
        if (abort)     nxt = S_IDLE;
        else if (wash) nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)      nxt = S_IDLE;
        else if (water) nxt = S_DEWATER;
      end
      S_DEWATER: begin
        if (abort) begin
          nxt = S_IDLE;
        end else if (dewater) begin
          rc_nxt  = rc_inc;
          cnt_nxt = 16'd0;
          nxt     = (int'(rc_inc) == ROUNDS) ? S_ALARM : S_SUPPLY;
        end
      end
      S_ALARM: begin
        if (abort || alarm) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from next state so they line up with state_out
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      supply_cnt <= 16'd0;
      round_cnt  <= 2'd0;
      fault      <= 1'b0;
      valve_in   <= 1'b0;
      motor      <= 1'b0;
      valve_out  <= 1'b0;
      buzzer     <= 1'b0;
    end else begin
      state      <= nxt;
      supply_cnt <= cnt_nxt;
      round_cnt  <= rc_nxt;
      fault      <= flt_nxt;
      valve_in   <= (nxt == S_SUPPLY);
      motor      <= (nxt == S_WASH) || (nxt == S_DEWATER);
      valve_out  <= (nxt == S_DRAIN) || (nxt == S_DEWATER);
      buzzer     <= (nxt == S_ALARM);
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_wash_ctrl.sv
// Bench for wash_ctrl: directed program scenarios followed by randomized inputs,
// every cycle compared against a phase-level reference model.
module tb_wash_ctrl;
  localparam int          ROUNDS = 2;
  localparam logic [15:0] TMO    = 16'd8;

  localparam int P_IDLE = 0, P_SUPPLY = 1, P_WASH = 2, P_DRAIN = 3, P_DEWATER = 4, P_ALARM = 5;

  logic       clk = 1'b0;
  logic       reset, start, abort, water_full, wash, water, dewater, alarm;
  logic [2:0] state_out;
  logic       valve_in, motor, valve_out, buzzer, fault;
  logic [1:0] round_cnt;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  int ph, rc, cycles_in_supply;
  bit flt;
  logic [2:0] code [6] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};

  wash_ctrl #(.ROUNDS(ROUNDS), .SUPPLY_TMO(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .water_full(water_full),
    .wash(wash), .water(water), .dewater(dewater), .alarm(alarm),
    .state_out(state_out), .valve_in(valve_in), .motor(motor), .valve_out(valve_out),
    .buzzer(buzzer), .round_cnt(round_cnt), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = P_IDLE; rc = 0; flt = 0; cycles_in_supply = 0;
  endtask

  // One clock of the program rules, applied to the inputs sampled at this edge
  task automatic model_clk();
    if (ph != P_IDLE && abort) begin
      ph = P_IDLE;
    end else begin
      case (ph)
        P_IDLE:    if (start && !abort) begin ph = P_SUPPLY; rc = 0; flt = 0; cycles_in_supply = 0; end
        P_SUPPLY: begin
          if (water_full) ph = P_WASH;
          else if (cycles_in_supply + 1 >= int'(TMO)) begin ph = P_ALARM; flt = 1; end
          else cycles_in_supply++;
        end
        P_WASH:    if (wash)  ph = P_DRAIN;
        P_DRAIN:   if (water) ph = P_DEWATER;
        P_DEWATER: if (dewater) begin
          rc = (rc < 3) ? rc + 1 : 3;
          if (rc == ROUNDS) ph = P_ALARM;
          else begin ph = P_SUPPLY; cycles_in_supply = 0; end
        end
        P_ALARM:   if (alarm) ph = P_IDLE;
        default:   ph = P_IDLE;
      endcase
    end
  endtask

  function automatic logic [15:0] expv();
    logic [1:0] r;
    r = rc[1:0];
    return {6'd0, code[ph], ph == P_SUPPLY, (ph == P_WASH) || (ph == P_DEWATER),
            (ph == P_DRAIN) || (ph == P_DEWATER), ph == P_ALARM, r, flt};
  endfunction

  function automatic logic [15:0] obsv();
    return {6'd0, state_out, valve_in, motor, valve_out, buzzer, round_cnt, fault};
  endfunction

  task automatic clr();
    start = 0; abort = 0; water_full = 0; wash = 0; water = 0; dewater = 0; alarm = 0;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_clk();
    #1;
    chk(tag, obsv(), expv());
  endtask

  initial begin
    clr();
    reset = 0;
    model_reset();
    #2;
    chk("reset_outputs", obsv(), 16'd0);
    @(posedge clk); #1;
    reset = 1;

    // Full two-round program
    start = 1; step("prog_start");
    chk("prog_supply", {13'd0, state_out}, 16'h1);
    start = 0;
    repeat (4) step("prog_fill");
    water_full = 1; step("prog_full");
    chk("prog_wash", {13'd0, state_out}, 16'h3);
    water_full = 0; wash = 1; step("prog_wash_done");
    chk("prog_drain", {13'd0, state_out}, 16'h2);
    wash = 0; water = 1; step("prog_drain_done");
    chk("prog_dewater", {13'd0, state_out}, 16'h6);
    water = 0; dewater = 1; step("prog_round1");
    chk("prog_round1_state", {13'd0, state_out}, 16'h1);
    chk("prog_round1_cnt", {14'd0, round_cnt}, 16'h1);
    dewater = 0; water_full = 1; step("prog_r2_full");
    water_full = 0; wash = 1; step("prog_r2_wash");
    wash = 0; water = 1; step("prog_r2_drain");
    water = 0; dewater = 1; step("prog_r2_dewater");
    chk("prog_alarm_state", {13'd0, state_out}, 16'h4);
    chk("prog_alarm_cnt", {14'd0, round_cnt}, 16'h2);
    chk("prog_buzzer", {15'd0, buzzer}, 16'h1);
    dewater = 0; alarm = 1; step("prog_alarm_done");
    chk("prog_idle_cnt_held", {14'd0, round_cnt}, 16'h2);
    alarm = 0;

    // Supply timeout
    start = 1; step("tmo_start");
    chk("tmo_cnt_cleared", {14'd0, round_cnt}, 16'h0);
    start = 0;
    repeat (7) step("tmo_wait");
    chk("tmo_still_supply", {13'd0, state_out}, 16'h1);
    step("tmo_expire");
    chk("tmo_alarm", {13'd0, state_out, buzzer, fault}, 16'h13);
    alarm = 1; step("tmo_alarm_done");
    chk("tmo_fault_held", {15'd0, fault}, 16'h1);
    alarm = 0; start = 1; step("tmo2_start");
    chk("tmo2_fault_cleared", {15'd0, fault}, 16'h0);
    start = 0;
    repeat (7) step("tmo2_wait");
    water_full = 1; step("tmo2_full_wins");
    chk("tmo2_wash", {13'd0, state_out, fault}, 16'h6);
    water_full = 0;

    // Drain flag held into dewater must not re-trigger
    wash = 1; step("hold_wash");
    wash = 0; water = 1; step("hold_drain");
    repeat (3) step("hold_dewater");
    chk("hold_state", {13'd0, state_out, motor, valve_out}, 16'h1B);
    water = 0;

    // Abort with wash flag the same cycle
    abort = 1; step("abort_dewater");
    abort = 0; start = 1; step("abort_start");
    start = 0; water_full = 1; step("abort_full");
    water_full = 0; abort = 1; wash = 1; step("abort_wash");
    chk("abort_idle", {13'd0, state_out, motor}, 16'h0);
    abort = 0; wash = 0;

    // Asynchronous reset during dewater
    start = 1; step("rst_start");
    start = 0; water_full = 1; step("rst_full");
    water_full = 0; wash = 1; step("rst_wash");
    wash = 0; water = 1; step("rst_drain");
    water = 0;
    chk("rst_in_dewater", {13'd0, state_out}, 16'h6);
    reset = 0; model_reset();
    #1;
    chk("rst_async", obsv(), 16'd0);
    #1; reset = 1;
    step("rst_idle_wait");
    start = 1; step("rst_restart");
    chk("rst_supply", {13'd0, state_out}, 16'h1);
    abort = 1; step("rst_abort");
    start = 1; abort = 1; step("start_and_abort");
    chk("start_abort_idle", {13'd0, state_out}, 16'h0);
    clr();

    // Randomized inputs with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom_range(0, 99) < 30);
      abort      = ($urandom_range(0, 99) < 3);
      water_full = ($urandom_range(0, 99) < 15);
      wash       = ($urandom_range(0, 99) < 35);
      water      = ($urandom_range(0, 99) < 35);
      dewater    = ($urandom_range(0, 99) < 35);
      alarm      = ($urandom_range(0, 99) < 35);
      if ($urandom_range(0, 299) == 0) begin
        reset = 0; model_reset();
        #1;
        chk("rand_reset", obsv(), 16'd0);
        #1; reset = 1;
      end
      step("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
